// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared encodings for the fetch/PC datapath front end:
//                PC source select codes, exception cause codes, the fetch
//                FSM state type and the default exception vector.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  // PC source select
  localparam logic [1:0] PCSRC_ALU_RESULT = 2'b00;
  localparam logic [1:0] PCSRC_ALU_OUT    = 2'b01;
  localparam logic [1:0] PCSRC_JUMP       = 2'b10;
  localparam logic [1:0] PCSRC_RS         = 2'b11;

  // Exception cause codes (also the exceptionBits encoding, except bus error)
  localparam logic [1:0] CAUSE_NONE       = 2'b00;
  localparam logic [1:0] CAUSE_BUS_ERR    = 2'b01;
  localparam logic [1:0] CAUSE_OVERFLOW   = 2'b10;
  localparam logic [1:0] CAUSE_INVALID    = 2'b11;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0080;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } fetch_state_e;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/pc_next_mux.sv
`default_nettype none
// ============================================================================
//  Module      : pc_next_mux
//  Description : Combinational 4:1 selection of the next program counter.
//  Revision    : 1.0 - initial release
//  Ports       :
//    pc_src_i      in  2   select (ALU result, ALU out, jump, rs)
//    alu_result_i  in  32  combinational ALU output
//    alu_out_i     in  32  registered ALU output (branch target)
//    rs_data_i     in  32  register rs value (jr/jalr)
//    pc_hi_i       in  4   current pc[31:28] for jump region
//    ir_target_i   in  26  current ir[25:0] jump index
//    pc_next_o     out 32  selected next PC
// ============================================================================
module pc_next_mux
  import fetch_pkg::*;
(
  input  logic [1:0]  pc_src_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] alu_out_i,
  input  logic [31:0] rs_data_i,
  input  logic [3:0]  pc_hi_i,
  input  logic [25:0] ir_target_i,
  output logic [31:0] pc_next_o
);

  always_comb begin
    pc_next_o = alu_result_i;
    case (pc_src_i)
      PCSRC_ALU_RESULT: pc_next_o = alu_result_i;
      PCSRC_ALU_OUT:    pc_next_o = alu_out_i;
      // Jump stays inside the current 256 MB region, word aligned.
      PCSRC_JUMP:       pc_next_o = {pc_hi_i, ir_target_i, 2'b00};
      PCSRC_RS:         pc_next_o = rs_data_i;
      default:          pc_next_o = alu_result_i;
    endcase
  end

endmodule : pc_next_mux
`default_nettype wire

// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pc_unit
//  Description : Datapath front end driven by the microprogrammed control
//                word. Owns PC, IR, MDR and EPC, runs the single-outstanding
//                memory handshake, and stalls the microsequencer while an
//                access is in flight. Exceptions (overflow, invalid opcode,
//                bus timeout) redirect the PC to EXC_VECTOR.
//  Revision    : 1.0 - initial release
//  Ports       :
//    clk, reset            clock / synchronous active-high reset
//    pcWr, pcWrCond, zero  PC write controls
//    pcSrc                 next-PC select
//    IorD                  0: fetch at PC, 1: data at aluOut
//    MemRd, MemWr, IRWr    memory / IR controls
//    exceptionBits         00 none, 10 overflow, 11 invalid
//    aluResult, aluOut     ALU values
//    rsData, wrData        register operands
//    mem_*                 memory request / response interface
//    stall                 hold the microsequencer
//    pc, ir, opCode, funcField, mdr, epc, cause, exc_valid  state outputs
// ============================================================================
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR  = EXC_VECTOR_DEFAULT,
  parameter int          MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pcWr,
  input  logic        pcWrCond,
  input  logic [1:0]  pcSrc,
  input  logic        IorD,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic        IRWr,
  input  logic [1:0]  exceptionBits,
  input  logic [31:0] aluResult,
  input  logic [31:0] aluOut,
  input  logic [31:0] rsData,
  input  logic [31:0] wrData,
  input  logic        zero,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        stall,
  output logic [31:0] pc,
  output logic [31:0] ir,
  output logic [5:0]  opCode,
  output logic [5:0]  funcField,
  output logic [31:0] mdr,
  output logic [31:0] epc,
  output logic [1:0]  cause,
  output logic        exc_valid
);

  localparam int              CNT_W      = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] c_TMO_LAST = CNT_W'(MEM_TIMEOUT - 1);

  fetch_state_e     state_q;
  logic [31:0]      pc_q, ir_q, mdr_q, epc_q, ir_pc_q;
  logic [31:0]      mem_addr_q, mem_wdata_q;
  logic [1:0]       cause_q;
  logic             mem_req_q, mem_we_q, exc_valid_q;
  logic [CNT_W-1:0] tmo_cnt_q;

  // Control decisions captured at request time, applied on ack.
  logic             lat_irwr_q, lat_rd_q, lat_pcwe_q;
  logic [31:0]      lat_pc_next_q;

  logic [31:0]      pc_next_d;
  logic             pc_we;
  logic             exc_req;
  logic             mem_start;

  assign pc_we     = pcWr | (pcWrCond & zero);
  assign exc_req   = (exceptionBits != CAUSE_NONE);
  assign mem_start = MemRd | MemWr;

  pc_next_mux u_pc_next_mux (
    .pc_src_i     (pcSrc),
    .alu_result_i (aluResult),
    .alu_out_i    (aluOut),
    .rs_data_i    (rsData),
    .pc_hi_i      (pc_q[31:28]),
    .ir_target_i  (ir_q[25:0]),
    .pc_next_o    (pc_next_d)
  );

  always_ff @(posedge clk) begin
    // exc_valid is a single-cycle pulse; only entry paths below raise it.
    exc_valid_q <= 1'b0;
    if (reset) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      ir_q          <= '0;
      mdr_q         <= '0;
      epc_q         <= '0;
      ir_pc_q       <= '0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      cause_q       <= CAUSE_NONE;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      tmo_cnt_q     <= '0;
      lat_irwr_q    <= 1'b0;
      lat_rd_q      <= 1'b0;
      lat_pcwe_q    <= 1'b0;
      lat_pc_next_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (exc_req) begin
            // The invalid-instruction control word asserts every bit, so
            // any same-cycle memory or PC write must be suppressed here.
            epc_q       <= ir_pc_q;
            cause_q     <= exceptionBits;
            exc_valid_q <= 1'b1;
            pc_q        <= EXC_VECTOR;
          end else if (mem_start) begin
            mem_req_q     <= 1'b1;
            mem_we_q      <= MemWr & ~MemRd;
            mem_addr_q    <= IorD ? aluOut : pc_q;
            mem_wdata_q   <= wrData;
            lat_irwr_q    <= IRWr;
            lat_rd_q      <= MemRd;
            lat_pcwe_q    <= pc_we;
            lat_pc_next_q <= pc_next_d;
            tmo_cnt_q     <= '0;
            state_q       <= ST_WAIT;
          end else if (pc_we) begin
            pc_q <= pc_next_d;
          end
        end

        ST_WAIT: begin
          if (mem_ack) begin
            if (lat_irwr_q) begin
              ir_q    <= mem_rdata;
              ir_pc_q <= mem_addr_q;
            end else if (lat_rd_q) begin
              mdr_q <= mem_rdata;
            end
            if (lat_pcwe_q) begin
              pc_q <= lat_pc_next_q;
            end
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            state_q   <= ST_IDLE;
          end else if (tmo_cnt_q == c_TMO_LAST) begin
            // Bus error: abandon the access and its latched writes.
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            cause_q     <= CAUSE_BUS_ERR;
            epc_q       <= mem_addr_q;
            pc_q        <= EXC_VECTOR;
            exc_valid_q <= 1'b1;
            tmo_cnt_q   <= '0;
            state_q     <= ST_IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Stall must rise in the same cycle the request is seen, hence combinational.
  assign stall = ((state_q == ST_IDLE) & mem_start & ~exc_req) | (state_q == ST_WAIT);

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign pc        = pc_q;
  assign ir        = ir_q;
  assign opCode    = ir_q[31:26];
  assign funcField = ir_q[5:0];
  assign mdr       = mdr_q;
  assign epc       = epc_q;
  assign cause     = cause_q;
  assign exc_valid = exc_valid_q;

endmodule : fetch_pc_unit
`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_pc_unit
//  Description : Self-checking bench for fetch_pc_unit. Expected results are
//                queued when stimulus is driven and popped when the DUT
//                completes the corresponding access or exception.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_unit;

  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR  = 32'h0000_0080;
  localparam int          MEM_TIMEOUT = 16;

  logic        clk, reset;
  logic        pcWr, pcWrCond, IorD, MemRd, MemWr, IRWr, zero, mem_ack;
  logic [1:0]  pcSrc, exceptionBits;
  logic [31:0] aluResult, aluOut, rsData, wrData, mem_rdata;
  logic        mem_req, mem_we, stall, exc_valid;
  logic [31:0] mem_addr, mem_wdata, pc, ir, mdr, epc;
  logic [5:0]  opCode, funcField;
  logic [1:0]  cause;

  fetch_pc_unit #(
    .RESET_PC    (RESET_PC),
    .EXC_VECTOR  (EXC_VECTOR),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) dut (
    .clk (clk), .reset (reset), .pcWr (pcWr), .pcWrCond (pcWrCond), .pcSrc (pcSrc),
    .IorD (IorD), .MemRd (MemRd), .MemWr (MemWr), .IRWr (IRWr),
    .exceptionBits (exceptionBits), .aluResult (aluResult), .aluOut (aluOut),
    .rsData (rsData), .wrData (wrData), .zero (zero), .mem_rdata (mem_rdata),
    .mem_ack (mem_ack), .mem_req (mem_req), .mem_we (mem_we), .mem_addr (mem_addr),
    .mem_wdata (mem_wdata), .stall (stall), .pc (pc), .ir (ir), .opCode (opCode),
    .funcField (funcField), .mdr (mdr), .epc (epc), .cause (cause), .exc_valid (exc_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] mdr;
    logic [31:0] addr;
    logic [31:0] epc;
    logic [1:0]  cause;
    int          stall_cycles;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference state kept by the bench
  logic [31:0] m_ir, m_mdr, m_ir_pc;

  task automatic clear_ctrl();
    pcWr = 0; pcWrCond = 0; pcSrc = 2'b00; IorD = 0; MemRd = 0; MemWr = 0; IRWr = 0;
    zero = 0; exceptionBits = 2'b00; aluResult = '0; aluOut = '0; rsData = '0; wrData = '0;
  endtask

  // Drives one memory access and acks it in the ack_delay-th WAIT cycle.
  task automatic do_access(input logic iord, input logic rd, input logic wr, input logic irwr,
                           input logic pcwr, input logic [1:0] src, input logic [31:0] alu_res,
                           input logic [31:0] alu_o, input logic [31:0] wd, input int ack_delay,
                           input logic [31:0] rdata, output logic [31:0] o_addr, output logic o_we,
                           output logic [31:0] o_wdata, output int o_stall);
    int stalls;
    stalls = 0;
    o_addr = '0; o_we = 1'b0; o_wdata = '0;
    @(negedge clk);
    IorD = iord; MemRd = rd; MemWr = wr; IRWr = irwr; pcWr = pcwr; pcSrc = src;
    aluResult = alu_res; aluOut = alu_o; wrData = wd;
    #1 if (stall) stalls++;
    for (int k = 1; k <= ack_delay; k++) begin
      @(negedge clk);
      if (k == 1) begin
        o_addr = mem_addr; o_we = mem_we & mem_req; o_wdata = mem_wdata;
      end
      if (k == ack_delay) begin
        clear_ctrl();
        mem_ack = 1'b1; mem_rdata = rdata;
      end
      #1 if (stall) stalls++;
    end
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = '0;
    #1 if (stall) stalls++;
    o_stall = stalls;
  endtask

  task automatic test_reset();
    clear_ctrl();
    mem_ack = 0; mem_rdata = '0; reset = 1;
    repeat (3) @(negedge clk);
    reset = 0;
    #1;
    n_checks++; if (pc !== RESET_PC) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", pc, RESET_PC); end
    n_checks++; if ({ir, mdr, epc} !== 96'h0) begin n_fail++; $display("FAIL reset_regs: got ir=%h mdr=%h epc=%h expected 0", ir, mdr, epc); end
    n_checks++; if ({mem_req, mem_we, exc_valid, stall, cause} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got req=%b we=%b exc=%b stall=%b cause=%b expected 0", mem_req, mem_we, exc_valid, stall, cause);
    end
    m_ir = '0; m_mdr = '0; m_ir_pc = '0;
  endtask

  task automatic test_fetch();
    exp_t e; logic [31:0] a, wdo; logic we; int st;
    e = '{pc: 32'h4, ir: 32'h20, mdr: m_mdr, addr: 32'h0, epc: '0, cause: '0, stall_cycles: 4};
    sb_q.push_back(e);
    do_access(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 32'h4, 32'h0, 32'h0, 3, 32'h0000_0020, a, we, wdo, st);
    if (sb_q.size() == 0) begin n_checks++; n_fail++; $display("FAIL fetch_sb: got empty queue expected entry"); end
    else begin
      e = sb_q.pop_front();
      n_checks++; if (a !== e.addr) begin n_fail++; $display("FAIL fetch_addr: got %h expected %h", a, e.addr); end
      n_checks++; if (ir !== e.ir) begin n_fail++; $display("FAIL fetch_ir: got %h expected %h", ir, e.ir); end
      n_checks++; if (opCode !== 6'd0 || funcField !== 6'd32) begin n_fail++; $display("FAIL fetch_fields: got op=%0d func=%0d expected 0/32", opCode, funcField); end
      n_checks++; if (pc !== e.pc) begin n_fail++; $display("FAIL fetch_pc: got %h expected %h", pc, e.pc); end
      n_checks++; if (st !== e.stall_cycles) begin n_fail++; $display("FAIL fetch_stall: got %0d expected %0d", st, e.stall_cycles); end
      n_checks++; if (mdr !== e.mdr) begin n_fail++; $display("FAIL fetch_mdr: got %h expected %h", mdr, e.mdr); end
      m_ir = e.ir; m_ir_pc = e.addr;
    end
  endtask

  task automatic test_branch();
    @(negedge clk);
    pcWrCond = 1; pcSrc = 2'b01; aluOut = 32'h40; zero = 1;
    @(negedge clk);
    clear_ctrl();
    n_checks++; if (pc !== 32'h40) begin n_fail++; $display("FAIL beq_taken: got %h expected %h", pc, 32'h40); end
    pcWrCond = 1; pcSrc = 2'b01; aluOut = 32'h80; zero = 0;
    @(negedge clk);
    clear_ctrl();
    n_checks++; if (pc !== 32'h40) begin n_fail++; $display("FAIL beq_not_taken: got %h expected %h", pc, 32'h40); end
  endtask

  task automatic test_jump();
    exp_t e; logic [31:0] a, wdo; logic we; int st;
    // Fetch the j instruction from 0x40 and move PC into region 0x1.
    e = '{pc: 32'h1000_0004, ir: 32'h0800_0010, mdr: m_mdr, addr: 32'h40, epc: '0, cause: '0, stall_cycles: 3};
    sb_q.push_back(e);
    do_access(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 32'h1000_0004, 32'h0, 32'h0, 2, 32'h0800_0010, a, we, wdo, st);
    e = sb_q.pop_front();
    n_checks++; if (a !== e.addr || ir !== e.ir || pc !== e.pc) begin
      n_fail++; $display("FAIL jfetch: got addr=%h ir=%h pc=%h expected %h %h %h", a, ir, pc, e.addr, e.ir, e.pc);
    end
    m_ir = e.ir; m_ir_pc = e.addr;
    @(negedge clk);
    pcWr = 1; pcSrc = 2'b10; aluResult = 32'hFFFF_FFFF;
    @(negedge clk);
    clear_ctrl();
    n_checks++; if (pc !== 32'h1000_0040) begin n_fail++; $display("FAIL jump_pc: got %h expected %h", pc, 32'h1000_0040); end
    pcWr = 1; pcSrc = 2'b11; rsData = 32'h200;
    @(negedge clk);
    clear_ctrl();
    n_checks++; if (pc !== 32'h200) begin n_fail++; $display("FAIL jr_pc: got %h expected %h", pc, 32'h200); end
  endtask

  task automatic test_load_store();
    exp_t e; logic [31:0] a, wdo; logic we; int st;
    // lw with minimum two-clock access
    e = '{pc: 32'h200, ir: m_ir, mdr: 32'hDEAD_BEEF, addr: 32'h100, epc: '0, cause: '0, stall_cycles: 2};
    sb_q.push_back(e);
    do_access(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h100, 32'h0, 1, 32'hDEAD_BEEF, a, we, wdo, st);
    e = sb_q.pop_front();
    n_checks++; if (a !== e.addr) begin n_fail++; $display("FAIL lw_addr: got %h expected %h", a, e.addr); end
    n_checks++; if (mdr !== e.mdr) begin n_fail++; $display("FAIL lw_mdr: got %h expected %h", mdr, e.mdr); end
    n_checks++; if (ir !== e.ir || pc !== e.pc) begin n_fail++; $display("FAIL lw_keep: got ir=%h pc=%h expected %h %h", ir, pc, e.ir, e.pc); end
    n_checks++; if (st !== e.stall_cycles) begin n_fail++; $display("FAIL lw_stall: got %0d expected %0d", st, e.stall_cycles); end
    m_mdr = e.mdr;
    // sw with a deferred PC write
    e = '{pc: 32'h204, ir: m_ir, mdr: m_mdr, addr: 32'h104, epc: '0, cause: '0, stall_cycles: 3};
    sb_q.push_back(e);
    do_access(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 32'h204, 32'h104, 32'hCAFE_F00D, 2, 32'h1111_2222, a, we, wdo, st);
    e = sb_q.pop_front();
    n_checks++; if (a !== e.addr || we !== 1'b1 || wdo !== 32'hCAFE_F00D) begin
      n_fail++; $display("FAIL sw_bus: got addr=%h we=%b wdata=%h expected %h 1 cafef00d", a, we, wdo, e.addr);
    end
    n_checks++; if (pc !== e.pc || mdr !== e.mdr || ir !== e.ir) begin
      n_fail++; $display("FAIL sw_state: got pc=%h mdr=%h ir=%h expected %h %h %h", pc, mdr, ir, e.pc, e.mdr, e.ir);
    end
    n_checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL sw_release: got req=%b we=%b expected 0 0", mem_req, mem_we); end
  endtask

  task automatic test_ack_idle();
    @(negedge clk);
    mem_ack = 1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    mem_ack = 0; mem_rdata = '0;
    #1;
    n_checks++; if (ir !== m_ir || mdr !== m_mdr || pc !== 32'h204) begin
      n_fail++; $display("FAIL idle_ack: got ir=%h mdr=%h pc=%h expected %h %h %h", ir, mdr, pc, m_ir, m_mdr, 32'h204);
    end
  endtask

  task automatic test_exception(input logic [1:0] bits);
    exp_t e;
    e = '{pc: EXC_VECTOR, ir: m_ir, mdr: m_mdr, addr: '0, epc: m_ir_pc, cause: bits, stall_cycles: 0};
    sb_q.push_back(e);
    @(negedge clk);
    pcWr = 1; pcWrCond = 1; zero = 1; pcSrc = 2'b11; IorD = 1; MemRd = 1; MemWr = 1; IRWr = 1;
    rsData = 32'h3333_0000; aluOut = 32'h444; exceptionBits = bits;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL exc%0d_stall: got %b expected 0", bits, stall); end
    @(negedge clk);
    e = sb_q.pop_front();
    n_checks++; if (mem_req !== 1'b0 || exc_valid !== 1'b1) begin
      n_fail++; $display("FAIL exc%0d_flags: got req=%b exc=%b expected 0 1", bits, mem_req, exc_valid);
    end
    n_checks++; if (pc !== e.pc || cause !== e.cause || epc !== e.epc) begin
      n_fail++; $display("FAIL exc%0d_state: got pc=%h cause=%b epc=%h expected %h %b %h", bits, pc, cause, epc, e.pc, e.cause, e.epc);
    end
    clear_ctrl();
    @(negedge clk);
    n_checks++; if (exc_valid !== 1'b0 || mem_req !== 1'b0) begin
      n_fail++; $display("FAIL exc%0d_pulse: got exc=%b req=%b expected 0 0", bits, exc_valid, mem_req);
    end
  endtask

  task automatic test_timeout();
    exp_t e; int edges; logic seen;
    @(negedge clk);
    pcWr = 1; pcSrc = 2'b00; aluResult = 32'h500;
    @(negedge clk);
    clear_ctrl();
    n_checks++; if (pc !== 32'h500) begin n_fail++; $display("FAIL tmo_setup_pc: got %h expected %h", pc, 32'h500); end
    e = '{pc: EXC_VECTOR, ir: m_ir, mdr: m_mdr, addr: 32'h300, epc: 32'h300, cause: 2'b01, stall_cycles: MEM_TIMEOUT + 1};
    sb_q.push_back(e);
    IorD = 1; MemRd = 1; IRWr = 1; pcWr = 1; aluResult = 32'h999; aluOut = 32'h300;
    edges = 0; seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      clear_ctrl();
      edges++;
      if (exc_valid) seen = 1;
    end
    e = sb_q.pop_front();
    n_checks++; if (!seen || edges !== e.stall_cycles) begin
      n_fail++; $display("FAIL tmo_latency: got seen=%b edges=%0d expected 1 %0d", seen, edges, e.stall_cycles);
    end
    n_checks++; if (cause !== e.cause || epc !== e.epc || pc !== e.pc || mem_req !== 1'b0) begin
      n_fail++; $display("FAIL tmo_state: got cause=%b epc=%h pc=%h req=%b expected %b %h %h 0", cause, epc, pc, mem_req, e.cause, e.epc, e.pc);
    end
    mem_ack = 1; mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    mem_ack = 0; mem_rdata = '0;
    @(negedge clk);
    n_checks++; if (ir !== e.ir || mdr !== e.mdr || pc !== e.pc || stall !== 1'b0) begin
      n_fail++; $display("FAIL tmo_late_ack: got ir=%h mdr=%h pc=%h stall=%b expected %h %h %h 0", ir, mdr, pc, stall, e.ir, e.mdr, e.pc);
    end
  endtask

  task automatic test_reset_in_wait();
    @(negedge clk);
    MemRd = 1; IRWr = 1; IorD = 0;
    @(negedge clk);
    clear_ctrl();
    n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rstw_req_up: got %b expected 1", mem_req); end
    reset = 1;
    @(negedge clk);
    reset = 0;
    n_checks++; if (mem_req !== 1'b0 || pc !== RESET_PC || stall !== 1'b0) begin
      n_fail++; $display("FAIL rstw_abort: got req=%b pc=%h stall=%b expected 0 %h 0", mem_req, pc, stall, RESET_PC);
    end
    mem_ack = 1; mem_rdata = 32'h7777_7777;
    @(negedge clk);
    mem_ack = 0; mem_rdata = '0;
    n_checks++; if (ir !== 32'h0 || mem_req !== 1'b0) begin
      n_fail++; $display("FAIL rstw_late_ack: got ir=%h req=%b expected 0 0", ir, mem_req);
    end
  endtask

  initial begin
    clear_ctrl();
    reset = 1; mem_ack = 0; mem_rdata = '0;
    m_ir = '0; m_mdr = '0; m_ir_pc = '0;
    test_reset();
    test_fetch();
    test_branch();
    test_jump();
    test_load_store();
    test_ack_idle();
    test_exception(2'b11);
    test_exception(2'b10);
    test_timeout();
    test_reset_in_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_fetch_pc_unit
`default_nettype wire
